// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder/subtractor.
// The operands are split into SEG_WIDTH-bit segments. Each segment is built
// from 4-bit lookahead groups and is resolved in its own pipeline stage. The
// carry between segments is registered, which skews the carry through the
// pipeline. One operation is accepted per cycle. A single global enable stalls
// every stage whenever the output is held by backpressure.
module cla_pipe_adder #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned SEG_WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_c_in,
  input  logic             i_sub,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_c_out,
  output logic             o_ovf,
  output logic             o_zero
);

  localparam int unsigned NSEG = WIDTH / SEG_WIDTH;
  localparam int unsigned NGRP = SEG_WIDTH / 4;

  if ((WIDTH % SEG_WIDTH) != 0 || (SEG_WIDTH % 4) != 0 || NSEG < 1) begin : g_param_check
    $error("cla_pipe_adder: WIDTH must be a non-zero multiple of SEG_WIDTH, SEG_WIDTH a multiple of 4");
  end

  // The B operand bits that are still unresolved are kept in one flat vector.
  // Stage j keeps B[WIDTH-1:(j+1)*SEG_WIDTH]. This function returns the offset
  // of that stage's region in the flat vector.
  function automatic int unsigned boff(input int unsigned stage);
    int unsigned off;
    off = 0;
    for (int unsigned m = 0; m < stage; m++) begin
      off += WIDTH - (m + 1) * SEG_WIDTH;
    end
    return off;
  endfunction

  localparam int unsigned BTOT = (NSEG > 1) ? boff(NSEG - 1) : 0;
  localparam int unsigned BW   = (BTOT == 0) ? 1 : BTOT;

  // 4-bit lookahead group.
  // Returns {group_generate, group_propagate, carry_into_bit3, sum[3:0]}.
  function automatic logic [6:0] cla4(input logic [3:0] a, input logic [3:0] b,
                                      input logic c0);
    logic [3:0] p;
    logic [3:0] g;
    logic [3:0] c;
    logic       gg;
    logic       pp;
    p    = a ^ b;
    g    = a & b;
    c[0] = c0;
    c[1] = g[0] | (p[0] & c0);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
    gg   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    pp   = &p;
    return {gg, pp, c[3], p ^ c};
  endfunction

  // One segment built from lookahead groups.
  // Returns {carry_out, carry_into_msb, sum}.
  function automatic logic [SEG_WIDTH+1:0] seg_add(input logic [SEG_WIDTH-1:0] a,
                                                   input logic [SEG_WIDTH-1:0] b,
                                                   input logic cin);
    logic [SEG_WIDTH-1:0] s;
    logic                 c;
    logic                 c_msb;
    logic [6:0]           r;
    s     = '0;
    c     = cin;
    c_msb = cin;
    for (int unsigned j = 0; j < NGRP; j++) begin
      r              = cla4(a[j*4 +: 4], b[j*4 +: 4], c);
      s[j*4 +: 4]    = r[3:0];
      c_msb          = r[4];
      c              = r[6] | (r[5] & c);
    end
    return {c, c_msb, s};
  endfunction

  // Pipeline state.
  // res_q[k] holds the resolved sum bits below (k+1)*SEG_WIDTH. Above those
  // bits it still carries the unresolved A operand.
  logic [NSEG-1:0]  vld_q, vld_d;
  logic [NSEG-1:0]  cry_q, cry_d;
  logic [WIDTH-1:0] res_q [NSEG];
  logic [WIDTH-1:0] res_d [NSEG];
  logic [BW-1:0]    bhi_q, bhi_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

  logic             en;
  logic [WIDTH-1:0] b_eff;
  logic             c_eff;
  logic [SEG_WIDTH+1:0] seg_r [NSEG];

  assign en      = !(vld_q[NSEG-1] && !i_ready);
  assign o_ready = en;
  assign o_valid = vld_q[NSEG-1];
  assign o_sum   = res_q[NSEG-1];
  assign o_c_out = cry_q[NSEG-1];
  assign o_ovf   = ovf_q;
  assign o_zero  = zero_q;

  // Operand conditioning and per-stage segment arithmetic.
  always_comb begin
    b_eff    = i_sub ? ~i_b : i_b;
    c_eff    = i_sub | i_c_in;
    seg_r[0] = seg_add(i_a[SEG_WIDTH-1:0], b_eff[SEG_WIDTH-1:0], c_eff);
    for (int unsigned k = 1; k < NSEG; k++) begin
      seg_r[k] = seg_add(res_q[k-1][k*SEG_WIDTH +: SEG_WIDTH],
                         bhi_q[boff(k-1) +: SEG_WIDTH], cry_q[k-1]);
    end
  end

  // Next state: advance all stages together when enabled, else hold.
  always_comb begin
    vld_d  = vld_q;
    res_d  = res_q;
    cry_d  = cry_q;
    bhi_d  = bhi_q;
    ovf_d  = ovf_q;
    zero_d = zero_q;
    if (en) begin
      vld_d[0]                = i_valid;
      res_d[0]                = i_a;
      res_d[0][SEG_WIDTH-1:0] = seg_r[0][SEG_WIDTH-1:0];
      cry_d[0]                = seg_r[0][SEG_WIDTH+1];
      for (int unsigned bit_i = SEG_WIDTH; bit_i < WIDTH; bit_i++) begin
        bhi_d[bit_i - SEG_WIDTH] = b_eff[bit_i];
      end
      for (int unsigned k = 1; k < NSEG; k++) begin
        vld_d[k]                             = vld_q[k-1];
        res_d[k]                             = res_q[k-1];
        res_d[k][k*SEG_WIDTH +: SEG_WIDTH]   = seg_r[k][SEG_WIDTH-1:0];
        cry_d[k]                             = seg_r[k][SEG_WIDTH+1];
        for (int unsigned bit_i = (k + 1) * SEG_WIDTH; bit_i < WIDTH; bit_i++) begin
          bhi_d[boff(k) + bit_i - (k + 1) * SEG_WIDTH] =
            bhi_q[boff(k-1) + bit_i - k * SEG_WIDTH];
        end
      end
      ovf_d  = seg_r[NSEG-1][SEG_WIDTH] ^ seg_r[NSEG-1][SEG_WIDTH+1];
      zero_d = ~|res_d[NSEG-1];
    end
  end

  // Pipeline registers. Asserting reset drops every operation in flight.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      vld_q  <= '0;
      res_q  <= '{default: '0};
      cry_q  <= '0;
      bhi_q  <= '0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      vld_q  <= vld_d;
      res_q  <= res_d;
      cry_q  <= cry_d;
      bhi_q  <= bhi_d;
      ovf_q  <= ovf_d;
      zero_q <= zero_d;
    end
  end

endmodule
